// File: rtl/sys_fifo_pkg.sv
// Shared constants and helpers for the sys_sync_fifo block.
// Holds the default data width and depth and the occupancy-counter width.
package sys_fifo_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 64;

  // The counter must represent 0..depth inclusive, hence one bit more than the pointer.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sys_fifo_ram.sv
// Storage array for sys_sync_fifo: DEPTH x DATA_W flops, one write port
// (synchronous) and one read port (asynchronous). Contents are never reset.
module sys_fifo_ram
  import sys_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     sys_clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Store the incoming word at the write address on an accepted write.
  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sys_sync_fifo.sv
// Single-clock FIFO with occupancy/room counts, threshold flags and sticky
// overrun/underrun flags. Define SYS_SYNC_FIFO_FWFT_EN for first-word-fall-through
// output; the default build gives a registered read port with one cycle latency.
module sys_sync_fifo
  import sys_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AF_LVL = DEPTH - 4,
  parameter int AE_LVL = 4
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     wr_en_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     rd_en_i,
  input  logic                     err_clr_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rd_valid_o,
  output logic                     fifo_empty_o,
  output logic                     fifo_full_o,
  output logic                     fifo_almost_empty_o,
  output logic                     fifo_almost_full_o,
  output logic                     fifo_overrun_o,
  output logic                     fifo_underrun_o,
  output logic [cnt_w(DEPTH)-1:0]  fifo_data_num_o,
  output logic [cnt_w(DEPTH)-1:0]  fifo_room_num_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] ram_rd_data;

  sys_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .sys_clk (sys_clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_data_i),
    .rd_addr (rd_ptr),
    .rd_data (ram_rd_data)
  );

  // Decide which requests are accepted and what the occupancy becomes after this edge.
  always_comb begin
    wr_acc    = wr_en_i && !fifo_full_o;
    rd_acc    = rd_en_i && !fifo_empty_o;
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers, occupancy and status flags; flags derive from the next count so they match it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
      fifo_empty_o        <= 1'b1;
      fifo_full_o         <= 1'b0;
      fifo_almost_empty_o <= 1'b1;
      fifo_almost_full_o  <= 1'b0;
      fifo_room_num_o     <= CNT_W'(DEPTH);
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count               <= count_nxt;
      fifo_empty_o        <= (count_nxt == '0);
      fifo_full_o         <= (count_nxt == CNT_W'(DEPTH));
      fifo_almost_empty_o <= (count_nxt <= CNT_W'(AE_LVL));
      fifo_almost_full_o  <= (count_nxt >= CNT_W'(AF_LVL));
      fifo_room_num_o     <= CNT_W'(DEPTH) - count_nxt;
    end
  end

  assign fifo_data_num_o = count;

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fifo_overrun_o  <= 1'b0;
      fifo_underrun_o <= 1'b0;
    end else begin
      if (wr_en_i && fifo_full_o) begin
        fifo_overrun_o <= 1'b1;
      end else if (err_clr_i) begin
        fifo_overrun_o <= 1'b0;
      end
      if (rd_en_i && fifo_empty_o) begin
        fifo_underrun_o <= 1'b1;
      end else if (err_clr_i) begin
        fifo_underrun_o <= 1'b0;
      end
    end
  end

`ifdef SYS_SYNC_FIFO_FWFT_EN
  // Head entry is shown directly; forced to zero while empty so reset shows a clean output.
  always_comb begin
    rd_valid_o = !fifo_empty_o;
    rd_data_o  = fifo_empty_o ? '0 : ram_rd_data;
  end
`else
  // Registered read port: load the head word on an accepted read and pulse valid for one cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_valid_o <= rd_acc;
      if (rd_acc) begin
        rd_data_o <= ram_rd_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sys_sync_fifo.sv
// Self-checking bench for sys_sync_fifo (DEPTH=16, DATA_W=16, AF_LVL=12, AE_LVL=4).
// A queue-based reference model predicts every output after each clock edge.
module tb_sys_sync_fifo;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int AF_LVL = 12;
  localparam int AE_LVL = 4;

  logic              sys_clk   = 1'b0;
  logic              sys_rst_n = 1'b1;
  logic              wr_en_i   = 1'b0;
  logic [DATA_W-1:0] wr_data_i = '0;
  logic              rd_en_i   = 1'b0;
  logic              err_clr_i = 1'b0;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_valid_o;
  logic              fifo_empty_o;
  logic              fifo_full_o;
  logic              fifo_almost_empty_o;
  logic              fifo_almost_full_o;
  logic              fifo_overrun_o;
  logic              fifo_underrun_o;
  logic [4:0]        fifo_data_num_o;
  logic [4:0]        fifo_room_num_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] model_q [$];
  logic              m_overrun  = 1'b0;
  logic              m_underrun = 1'b0;
  logic              m_valid    = 1'b0;
  logic [DATA_W-1:0] m_data     = '0;

  sys_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AF_LVL (AF_LVL),
    .AE_LVL (AE_LVL)
  ) dut (
    .sys_clk             (sys_clk),
    .sys_rst_n           (sys_rst_n),
    .wr_en_i             (wr_en_i),
    .wr_data_i           (wr_data_i),
    .rd_en_i             (rd_en_i),
    .err_clr_i           (err_clr_i),
    .rd_data_o           (rd_data_o),
    .rd_valid_o          (rd_valid_o),
    .fifo_empty_o        (fifo_empty_o),
    .fifo_full_o         (fifo_full_o),
    .fifo_almost_empty_o (fifo_almost_empty_o),
    .fifo_almost_full_o  (fifo_almost_full_o),
    .fifo_overrun_o      (fifo_overrun_o),
    .fifo_underrun_o     (fifo_underrun_o),
    .fifo_data_num_o     (fifo_data_num_o),
    .fifo_room_num_o     (fifo_room_num_o)
  );

  // Free-running 100 MHz clock.
  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    int sz;
    sz = model_q.size();
    checkOutput({tag, ".count"},    32'(fifo_data_num_o),     32'(sz));
    checkOutput({tag, ".room"},     32'(fifo_room_num_o),     32'(DEPTH - sz));
    checkOutput({tag, ".empty"},    32'(fifo_empty_o),        32'(sz == 0));
    checkOutput({tag, ".full"},     32'(fifo_full_o),         32'(sz == DEPTH));
    checkOutput({tag, ".a_empty"},  32'(fifo_almost_empty_o), 32'(sz <= AE_LVL));
    checkOutput({tag, ".a_full"},   32'(fifo_almost_full_o),  32'(sz >= AF_LVL));
    checkOutput({tag, ".overrun"},  32'(fifo_overrun_o),      32'(m_overrun));
    checkOutput({tag, ".underrun"}, 32'(fifo_underrun_o),     32'(m_underrun));
    checkOutput({tag, ".valid"},    32'(rd_valid_o),          32'(m_valid));
    checkOutput({tag, ".data"},     32'(rd_data_o),           32'(m_data));
  endtask

  // One clock of stimulus: drive at negedge, update model at posedge, check at next negedge.
  task automatic applyStimulus(input string tag, input logic wr, input logic [DATA_W-1:0] data,
                               input logic rd, input logic clr);
    logic wr_acc;
    logic rd_acc;
    wr_en_i   = wr;
    wr_data_i = data;
    rd_en_i   = rd;
    err_clr_i = clr;
    @(posedge sys_clk);
    wr_acc = wr && (model_q.size() < DEPTH);
    rd_acc = rd && (model_q.size() > 0);
    if (wr && model_q.size() == DEPTH) m_overrun = 1'b1;
    else if (clr) m_overrun = 1'b0;
    if (rd && model_q.size() == 0) m_underrun = 1'b1;
    else if (clr) m_underrun = 1'b0;
`ifndef SYS_SYNC_FIFO_FWFT_EN
    m_valid = rd_acc;
    if (rd_acc) m_data = model_q[0];
`endif
    if (rd_acc) void'(model_q.pop_front());
    if (wr_acc) model_q.push_back(data);
`ifdef SYS_SYNC_FIFO_FWFT_EN
    m_valid = (model_q.size() > 0);
    m_data  = (model_q.size() > 0) ? model_q[0] : '0;
`endif
    @(negedge sys_clk);
    wr_en_i   = 1'b0;
    rd_en_i   = 1'b0;
    err_clr_i = 1'b0;
    checkAll(tag);
  endtask

  // Asynchronous reset away from any clock edge; outputs are checked before the next edge.
  task automatic doReset(input string tag);
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    model_q.delete();
    m_overrun  = 1'b0;
    m_underrun = 1'b0;
    m_valid    = 1'b0;
    m_data     = '0;
    #1 checkAll(tag);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    checkAll({tag, "_release"});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH && model_q.size() > 0; i++) begin
      applyStimulus(tag, 1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    logic [DATA_W-1:0] rnd;
    int wr_pct;

    #1 sys_rst_n = 1'b0;
    #2 checkAll("reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // Fill to full with 1..16, then one extra write must be refused and flag overrun.
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus("fill", 1'b1, DATA_W'(i), 1'b0, 1'b0);
      if (i == AF_LVL) checkOutput("af_at_12th", 32'(fifo_almost_full_o), 32'd1);
    end
    applyStimulus("over_wr", 1'b1, 16'hDEAD, 1'b0, 1'b0);
    checkOutput("over_full", 32'(fifo_full_o), 32'd1);
    checkOutput("over_flag", 32'(fifo_overrun_o), 32'd1);
    checkOutput("over_room", 32'(fifo_room_num_o), 32'd0);

    // Drain in order, then an extra read must flag underrun; one clear cycle drops both flags.
    drain("drain");
    applyStimulus("under_rd", 1'b0, '0, 1'b1, 1'b0);
    checkOutput("under_flag", 32'(fifo_underrun_o), 32'd1);
    applyStimulus("err_clr", 1'b0, '0, 1'b0, 1'b1);
    checkOutput("clr_under", 32'(fifo_underrun_o), 32'd0);

    // Steady-state streaming at occupancy 5 long enough to wrap both pointers.
    for (int i = 0; i < 5; i++) applyStimulus("pre5", 1'b1, DATA_W'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) applyStimulus("stream", 1'b1, DATA_W'($urandom), 1'b1, 1'b0);
    checkOutput("stream_cnt", 32'(fifo_data_num_o), 32'd5);
    drain("drain5");

    // Simultaneous access at the full and empty boundaries.
    for (int i = 0; i < DEPTH; i++) applyStimulus("fill2", 1'b1, DATA_W'($urandom), 1'b0, 1'b0);
    applyStimulus("both_full", 1'b1, 16'h1234, 1'b1, 1'b0);
    checkOutput("both_full_cnt", 32'(fifo_data_num_o), 32'd15);
    checkOutput("both_full_ovr", 32'(fifo_overrun_o), 32'd1);
    drain("drain15");
    applyStimulus("both_empty", 1'b1, 16'h4321, 1'b1, 1'b0);
    checkOutput("both_empty_cnt", 32'(fifo_data_num_o), 32'd1);
    checkOutput("both_empty_und", 32'(fifo_underrun_o), 32'd1);
    drain("drain1");
    applyStimulus("err_clr2", 1'b0, '0, 1'b0, 1'b1);

    // Read latency / fall-through visibility of a single word.
    applyStimulus("abcd_wr", 1'b1, 16'hABCD, 1'b0, 1'b0);
`ifdef SYS_SYNC_FIFO_FWFT_EN
    checkOutput("fwft_valid", 32'(rd_valid_o), 32'd1);
    checkOutput("fwft_data", 32'(rd_data_o), 32'hABCD);
    applyStimulus("abcd_rd", 1'b0, '0, 1'b1, 1'b0);
`else
    checkOutput("reg_novalid", 32'(rd_valid_o), 32'd0);
    applyStimulus("abcd_rd", 1'b0, '0, 1'b1, 1'b0);
    checkOutput("reg_valid", 32'(rd_valid_o), 32'd1);
    checkOutput("reg_data", 32'(rd_data_o), 32'hABCD);
    applyStimulus("abcd_hold", 1'b0, '0, 1'b0, 1'b0);
    checkOutput("reg_hold", 32'(rd_data_o), 32'hABCD);
`endif

    // Randomised traffic with a write-heavy then a read-heavy phase and occasional clears.
    for (int i = 0; i < 400; i++) begin
      wr_pct = (i < 200) ? 70 : 30;
      rnd = DATA_W'($urandom);
      applyStimulus("random", ($urandom_range(0, 99) < wr_pct), rnd,
                    ($urandom_range(0, 99) < (100 - wr_pct)), ($urandom_range(0, 15) == 0));
    end

    // Reset with nine words queued, then confirm the next write reads back.
    drain("drain_pre");
    for (int i = 0; i < 9; i++) applyStimulus("pre9", 1'b1, DATA_W'($urandom), 1'b0, 1'b0);
    checkOutput("pre9_cnt", 32'(fifo_data_num_o), 32'd9);
    doReset("mid_reset");
    applyStimulus("post_wr", 1'b1, 16'h5A5A, 1'b0, 1'b0);
    applyStimulus("post_rd", 1'b0, '0, 1'b1, 1'b0);
`ifndef SYS_SYNC_FIFO_FWFT_EN
    checkOutput("post_data", 32'(rd_data_o), 32'h5A5A);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
